enigma_rotor: RTL and testbench

- Single Enigma-style substitution rotor for the ENIGMA551 datapath; letters are encoded 0..25 (A..Z) on 5 bits.
- Holds a rotational position register and applies a fixed wiring permutation, offset by position and ring setting.
- Substitution is combinational in either direction (forward toward the reflector, reverse on the return path).
- Produces a carry to step the next rotor in the stack.

---
 rtl/enigma_rotor.sv | 146 ++++++++++++++
 tb/tb_enigma_rotor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor.sv
`timescale 1ns/1ps
// enigma_rotor: single Enigma-style substitution rotor.
// Letters are 0..25 (A..Z) on 5 bits. The wiring permutation is applied through a
// rotating contact offset (position) and a fixed ring setting. Substitution is purely
// combinational in both directions; the only state is the position register.
module enigma_rotor #(
   parameter int unsigned ROTOR_ID = 1,
   parameter int unsigned RING     = 0,
   parameter int unsigned INIT_POS = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] data_in,
   input  logic       rotate,
   input  logic       reverse,
   input  logic       load_en,
   input  logic [4:0] load_pos,
   output logic [4:0] data_out,
   output logic [4:0] position,
   output logic       at_notch,
   output logic       carry_out
);

   // One 5-bit entry per input letter, index 0 (A) is the leftmost element.
   typedef logic [0:25][4:0] table_t;

   // Rotor I:   EKMFLGDQVZNTOWYHXUSPAIBRCJ
   localparam table_t W_I = {
      5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
      5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
      5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
   };

   // Rotor II:  AJDKSIRUXBLHWTMCQGZNPYFVOE
   localparam table_t W_II = {
      5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
      5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
      5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
   };

   // Rotor III: BDFHJLCPRTXVZNYEIWGAKMUSQO
   localparam table_t W_III = {
      5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19,
      5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,
      5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
   };

   // Rotor IV:  ESOVPZJAYQUIRHXLNFTGKDCMWB
   localparam table_t W_IV = {
      5'd4,  5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9,  5'd0,  5'd24, 5'd16,
      5'd20, 5'd8,  5'd17, 5'd7,  5'd23, 5'd11, 5'd13, 5'd5,  5'd19, 5'd6,
      5'd10, 5'd3,  5'd2,  5'd12, 5'd22, 5'd1
   };

   // Rotor V:   VZBRGITYUPJHLDMCSKFXEONQWA
   localparam table_t W_V = {
      5'd21, 5'd25, 5'd1,  5'd17, 5'd6,  5'd8,  5'd19, 5'd24, 5'd20, 5'd15,
      5'd9,  5'd7,  5'd11, 5'd3,  5'd12, 5'd2,  5'd18, 5'd10, 5'd5,  5'd23,
      5'd4,  5'd14, 5'd13, 5'd16, 5'd22, 5'd0
   };

   // Unknown rotor ids fall back to rotor I.
   localparam int unsigned SEL = (ROTOR_ID >= 1 && ROTOR_ID <= 5) ? ROTOR_ID : 1;

   localparam table_t WIRING = (SEL == 2) ? W_II  :
                               (SEL == 3) ? W_III :
                               (SEL == 4) ? W_IV  :
                               (SEL == 5) ? W_V   : W_I;

   localparam logic [4:0] NOTCH = (SEL == 2) ? 5'd4  :
                                  (SEL == 3) ? 5'd21 :
                                  (SEL == 4) ? 5'd9  :
                                  (SEL == 5) ? 5'd25 : 5'd16;

   // Inverse permutation built at elaboration so that INV[WIRING[x]] == x.
   function automatic table_t invert(input table_t w);
      table_t inv;
      inv = '0;
      for (int k = 0; k < 26; k++) begin
         inv[w[k]] = 5'(k);
      end
      return inv;
   endfunction

   localparam table_t INV = invert(WIRING);

   // Ring setting folded into constants: adding RING_COMP is "- RING" without going negative.
   localparam logic [6:0] RING_7     = 7'(RING % 26);
   localparam logic [6:0] RING_COMP  = 7'(26 - (RING % 26));
   localparam logic [4:0] INIT_POS_5 = 5'(INIT_POS % 26);

   // Reduce a 7-bit sum (at most 103) into 0..25 by conditional subtraction.
   function automatic logic [4:0] mod26(input logic [6:0] v);
      logic [6:0] r;
      if (v >= 7'd78) begin
         r = v - 7'd78;
      end else if (v >= 7'd52) begin
         r = v - 7'd52;
      end else if (v >= 7'd26) begin
         r = v - 7'd26;
      end else begin
         r = v;
      end
      return 5'(r);
   endfunction

   logic [4:0] position_q, position_d;
   logic [4:0] c_idx;
   logic [4:0] mapped;
   logic [4:0] sub_out;

   // Next position: a valid load wins over a step; an out-of-range load holds.
   always_comb begin
      position_d = position_q;
      if (load_en) begin
         if (load_pos <= 5'd25) begin
            position_d = load_pos;
         end
      end else if (rotate) begin
         position_d = (position_q == 5'd25) ? 5'd0 : position_q + 5'd1;
      end
   end

   // Position register, asynchronously forced to INIT_POS while reset is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position_q <= INIT_POS_5;
      end else begin
         position_q <= position_d;
      end
   end

   // Substitution path: shift into the wiring frame, look up, shift back out.
   always_comb begin
      c_idx    = mod26(7'(data_in) + 7'(position_q) + RING_COMP);
      mapped   = reverse ? INV[c_idx] : WIRING[c_idx];
      // +26 first so subtracting the position can never underflow.
      sub_out  = mod26(7'(mapped) + 7'd26 - 7'(position_q) + RING_7);
      data_out = (data_in >= 5'd26) ? data_in : sub_out;
   end

   assign position  = position_q;
   assign at_notch  = (position_q == NOTCH);
   assign carry_out = rotate & at_notch;

endmodule

// File: tb/tb_enigma_rotor.sv
`timescale 1ns/1ps
// Bench for enigma_rotor: six rotor instances share one stimulus stream; a
// string-based reference model predicts every output, expectations are queued and
// a negedge monitor pops and compares them.
module tb_enigma_rotor;

   localparam int N = 6;
   localparam int unsigned CFG_ID   [N] = '{1, 3, 2, 4, 5, 9};
   localparam int unsigned CFG_RING [N] = '{0, 1, 4, 11, 7, 25};
   localparam int unsigned CFG_INIT [N] = '{0, 0, 3, 25, 20, 13};

   logic       clk;
   logic       rst_n;
   logic [4:0] data_in;
   logic       rotate;
   logic       reverse;
   logic       load_en;
   logic [4:0] load_pos;
   logic [4:0] dout   [N];
   logic [4:0] pos    [N];
   logic       notch  [N];
   logic       carry  [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      enigma_rotor #(
         .ROTOR_ID (CFG_ID[g]),
         .RING     (CFG_RING[g]),
         .INIT_POS (CFG_INIT[g])
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .data_in   (data_in),
         .rotate    (rotate),
         .reverse   (reverse),
         .load_en   (load_en),
         .load_pos  (load_pos),
         .data_out  (dout[g]),
         .position  (pos[g]),
         .at_notch  (notch[g]),
         .carry_out (carry[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   string wires [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                        "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                        "VZBRGITYUPJHLDMCSKFXEONQWA"};
   string notches = "QEVJZ";
   int    mpos [N];

   function automatic int sel(int unsigned id);
      return (id >= 1 && id <= 5) ? int'(id) - 1 : 0;
   endfunction

   function automatic int wmap(int unsigned id, int k);
      return int'(wires[sel(id)].getc(k)) - 65;
   endfunction

   function automatic int notch_of(int i);
      return int'(notches.getc(sel(CFG_ID[i]))) - 65;
   endfunction

   function automatic int m26(int v);
      return ((v % 26) + 26) % 26;
   endfunction

   function automatic int ref_out(int i, int x, int rev, int p);
      int c, y;
      if (x >= 26) return x;
      c = m26(x + p - int'(CFG_RING[i]));
      y = 0;
      if (rev == 0) begin
         y = wmap(CFG_ID[i], c);
      end else begin
         for (int k = 0; k < 26; k++) if (wmap(CFG_ID[i], k) == c) y = k;
      end
      return m26(y - p + int'(CFG_RING[i]));
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      string tag;
      int    inst;
      int    dout;
      int    pos;
      int    notch;
      int    carry;
      bit    full;
   } exp_t;

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;

   task automatic push_model(string tag);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.tag   = tag;
         e.inst  = i;
         e.dout  = ref_out(i, int'(data_in), int'(reverse), mpos[i]);
         e.pos   = mpos[i];
         e.notch = (mpos[i] == notch_of(i)) ? 1 : 0;
         e.carry = (rotate && mpos[i] == notch_of(i)) ? 1 : 0;
         e.full  = 1'b1;
         sb.push_back(e);
      end
   endtask

   // Fixed expectation (data_out and position only) for one instance.
   task automatic push_lit(string tag, int inst, int d, int p);
      exp_t e;
      e.tag   = tag;
      e.inst  = inst;
      e.dout  = d;
      e.pos   = p;
      e.notch = 0;
      e.carry = 0;
      e.full  = 1'b0;
      sb.push_back(e);
   endtask

   // Monitor: compare everything queued against the settled outputs on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (int'(dout[e.inst]) != e.dout || int'(pos[e.inst]) != e.pos ||
                (e.full && (int'(notch[e.inst]) != e.notch ||
                            int'(carry[e.inst]) != e.carry))) begin
               errors++;
               $display("FAIL %s inst%0d: got dout=%0d pos=%0d notch=%0b carry=%0b, want dout=%0d pos=%0d notch=%0d carry=%0d%s",
                        e.tag, e.inst, dout[e.inst], pos[e.inst], notch[e.inst], carry[e.inst],
                        e.dout, e.pos, e.notch, e.carry, e.full ? "" : " (notch/carry unchecked)");
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Advance the model across one rising edge using the inputs the DUT just sampled.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            mpos[i] = int'(CFG_INIT[i]);
         end else if (load_en) begin
            if (load_pos <= 5'd25) mpos[i] = int'(load_pos);
         end else if (rotate) begin
            mpos[i] = (mpos[i] + 1) % 26;
         end
      end
      #1;
   endtask

   task automatic drive(int din, bit rot, bit rev, bit ld, int lp, string tag);
      tick();
      data_in  = 5'(din);
      rotate   = rot;
      reverse  = rev;
      load_en  = ld;
      load_pos = 5'(lp);
      push_model(tag);
   endtask

   initial begin
      int y;
      rst_n    = 1'b0;
      data_in  = 5'd0;
      rotate   = 1'b0;
      reverse  = 1'b0;
      load_en  = 1'b0;
      load_pos = 5'd0;
      for (int i = 0; i < N; i++) mpos[i] = int'(CFG_INIT[i]);

      tick();
      push_model("in_reset");
      tick();
      rst_n = 1'b1;
      push_model("after_reset");
      push_lit("reset_a", 0, 4, 0);
      drive(1, 0, 0, 0, 0, "fwd_b");
      push_lit("fwd_b", 0, 10, 0);

      // Single step, then the shifted substitution.
      drive(2, 1, 0, 0, 0, "step");
      drive(2, 0, 0, 0, 0, "pos1_c");
      push_lit("pos1_c", 0, 4, 1);
      drive(0, 0, 0, 0, 0, "pos1_a");
      push_lit("pos1_a", 0, 9, 1);

      // Rotate held high for a full revolution, covering the notch and the 25->0 wrap.
      for (int k = 0; k < 27; k++) begin
         drive(int'($urandom_range(0, 25)), 1'b1, 1'($urandom_range(0, 1)), 0, 0, "walk");
      end
      drive(0, 0, 0, 0, 0, "walk_stop");

      // Reverse path at position 0.
      drive(0, 0, 0, 1, 0, "load0");
      drive(4, 0, 1, 0, 0, "rev_e");
      push_lit("rev_e", 0, 0, 0);
      drive(10, 0, 1, 0, 0, "rev_k");
      push_lit("rev_k", 0, 1, 0);

      // reverse(forward(x)) == x at position 5.
      drive(0, 0, 0, 1, 5, "load5");
      for (int x = 0; x < 26; x++) begin
         y = ref_out(0, x, 0, 5);
         drive(y, 0, 1, 0, 0, "roundtrip");
         push_lit("roundtrip", 0, x, 5);
      end

      // Load priority, invalid load, invalid letter.
      drive(0, 1, 0, 1, 16, "ld_vs_rot");
      drive(0, 0, 0, 0, 0, "ld_win");
      push_lit("ld_win", 0, ref_out(0, 0, 0, 16), 16);
      drive(0, 1, 0, 1, 27, "ld_bad_carry");
      drive(30, 0, 0, 0, 0, "ld_bad_hold");
      push_lit("ld_bad_hold", 0, 30, 16);
      drive(31, 0, 1, 0, 0, "invalid_rev");
      push_lit("invalid_rev", 0, 31, 16);

      // Asynchronous reset pulse with no rising edge while low.
      drive(0, 0, 0, 1, 7, "load7");
      drive(3, 0, 0, 0, 0, "at7");
      push_lit("at7", 0, ref_out(0, 3, 0, 7), 7);
      tick();
      #2;
      rst_n  = 1'b0;
      rotate = 1'b1;
      for (int i = 0; i < N; i++) mpos[i] = int'(CFG_INIT[i]);
      push_model("async_rst");
      push_lit("async_rst", 0, ref_out(0, 3, 0, 0), 0);
      #3;
      rst_n = 1'b1;
      drive(3, 0, 0, 0, 0, "first_step");
      push_lit("first_step", 0, ref_out(0, 3, 0, 1), 1);

      // Rotor III with ring 1 at position 0.
      drive(0, 0, 0, 1, 0, "load0b");
      drive(0, 0, 0, 0, 0, "id3_ring1");
      push_lit("id3_ring1", 1, 15, 0);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         drive(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 31)), "random");
      end
      drive(0, 0, 0, 0, 0, "idle");

      // Bounded drain of the scoreboard.
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
